nco_counter: RTL and testbench

//  Numerically controlled oscillator built from a free-running 9-bit phase

---
 rtl/nco_counter.sv | 43 ++++
 tb/tb_nco_counter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/nco_counter.sv
// nco_counter: free-running 9-bit phase counter indexing two half-period sine RAMs with a two-stage output pipeline
module nco_counter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int PHASE_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csb00,
  input  logic              csb01,
  input  logic [ADDR_W-1:0] addr00,
  input  logic [ADDR_W-1:0] addr01,
  input  logic [DATA_W-1:0] din00,
  input  logic [DATA_W-1:0] din01,
  output logic [DATA_W-1:0] sine_out
);
  localparam logic [ADDR_W:0] STEP = (ADDR_W+1)'(PHASE_STEP);
  logic [DATA_W-1:0] mem0 [2**ADDR_W];
  logic [DATA_W-1:0] mem1 [2**ADDR_W];
  logic [ADDR_W:0]   phase;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              sel_d;
  always_ff @(posedge clk) begin
    if (!csb00) mem0[addr00] <= din00;
    if (!csb01) mem1[addr01] <= din01;
  end
  // reads sample the pre-write contents, so a same-cycle collision returns the old word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase    <= '0;
      rdata0   <= '0;
      rdata1   <= '0;
      sel_d    <= 1'b0;
      sine_out <= '0;
    end else begin
      phase    <= phase + STEP;
      rdata0   <= mem0[phase[ADDR_W-1:0]];
      rdata1   <= mem1[phase[ADDR_W-1:0]];
      sel_d    <= phase[ADDR_W];
      sine_out <= sel_d ? rdata1 : rdata0;
    end
  end
endmodule

// File: tb/tb_nco_counter.sv
// tb_nco_counter: scoreboard bench; a table-level model predicts each sine_out sample
module tb_nco_counter;
  logic clk = 1'b0, rst = 1'b0, csb00 = 1'b1, csb01 = 1'b1;
  logic [7:0] addr00 = '0, addr01 = '0;
  logic [15:0] din00 = '0, din01 = '0;
  logic [15:0] sine_out;
  nco_counter dut (
    .clk(clk), .rst(rst), .csb00(csb00), .csb01(csb01),
    .addr00(addr00), .addr01(addr01), .din00(din00), .din01(din01),
    .sine_out(sine_out)
  );
  always #5 clk = ~clk;
  int n_checks = 0, n_fail = 0;
  logic [15:0] m0 [256], m1 [256], t0 [256], t1 [256];
  bit v0 [256], v1 [256];
  int mph = 0;
  logic [15:0] s1_val = '0;
  bit s1_ok = 1'b1;
  typedef struct { logic [15:0] val; bit ok; } exp_t;
  exp_t q [$];
  function automatic void check(string n, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
    end
  endfunction
  // model: sine_out after an edge is the table word read at the previous edge
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      mph = 0; s1_val = '0; s1_ok = 1'b1; q.delete();
    end else begin
      q.push_back('{val: s1_val, ok: s1_ok});
      if (mph < 256) begin s1_val = m0[mph]; s1_ok = v0[mph]; end
      else begin s1_val = m1[mph-256]; s1_ok = v1[mph-256]; end
      if (!csb00) begin m0[addr00] = din00; v0[addr00] = 1'b1; end
      if (!csb01) begin m1[addr01] = din01; v1[addr01] = 1'b1; end
      mph = (mph + 1) % 512;
    end
  end
  initial forever begin
    @(negedge clk);
    if (!rst) check("reset_out", sine_out, 16'h0000);
    else if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.ok) check("sample", sine_out, e.val);
    end
  end
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int x, k;
    bit found;
    real r;
    for (int i = 0; i < 512; i++) begin
      r = $sin(2.0 * 3.141592653589793 * i / 512.0) * 32767.0;
      r = r + ((r >= 0.0) ? 1.0e-6 : -1.0e-6);
      if (i < 256) t0[i] = 16'($rtoi(r));
      else t1[i-256] = 16'($rtoi(r));
    end
    repeat (4) cyc();
    check("reset_phase", 16'(dut.phase), 16'h0000);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      cyc();
      csb00 = 1'b0; csb01 = 1'b0;
      addr00 = 8'(i); addr01 = 8'(255 - i);
      din00 = t0[i]; din01 = t1[255 - i];
    end
    cyc();
    csb00 = 1'b1; csb01 = 1'b1;
    check("t0_64", dut.mem0[64], 16'h5A81);
    check("t0_128", dut.mem0[128], 16'h7FFF);
    check("t1_0", dut.mem1[0], 16'h0000);
    check("t1_128", dut.mem1[128], 16'h8001);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("async_reset", sine_out, 16'h0000);
    #1 rst = 1'b1;
    repeat (520) cyc();
    for (int i = 0; i < 300; i++) begin
      cyc();
      csb00 = 1'b1; addr00 = 8'($urandom); din00 = 16'($urandom);
      csb01 = (i == 100) ? 1'b0 : 1'b1; addr01 = 8'd40; din01 = 16'($urandom);
    end
    cyc();
    csb01 = 1'b1;
    repeat (600) cyc();
    for (int i = 0; i < 256; i++) check("ram0_gated", dut.mem0[i], t0[i]);
    x = $urandom_range(0, 255);
    found = 1'b0;
    k = 0;
    while (k < 600 && !found) begin
      cyc();
      if (mph == x) begin
        csb00 = 1'b0; addr00 = 8'(x); din00 = ~m0[x]; found = 1'b1;
      end
      k++;
    end
    check("collision_wait", 16'(found), 16'h0001);
    cyc();
    csb00 = 1'b1;
    repeat (600) cyc();
    for (int i = 0; i < 300; i++) begin
      cyc();
      csb00 = 1'($urandom); csb01 = 1'($urandom);
      addr00 = 8'($urandom); addr01 = 8'($urandom);
      din00 = 16'($urandom); din01 = 16'($urandom);
    end
    cyc();
    csb00 = 1'b1; csb01 = 1'b1;
    repeat (600) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
